// File: rtl/serial_add_sub_if.sv
// Bundles the request/result signals between a controller and the bit-serial adder/subtractor.
// Handshake: start is sampled only while busy=0; the operands and sub are taken on that edge, and
//   done pulses for exactly one cycle when result/carry_out/overflow hold the new, valid values.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, carry_out, overflow
    );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell and a registered carry, LSB first.
// Subtraction adds ~b with the carry preset to 1; result and flags only change when entering DONE.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_sub_if.slave   bus,
    output logic [1:0]        dbg_state
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;

    logic             sum_bit;
    logic             carry_next;

    // The single full-adder cell working on the current LSBs.
    assign sum_bit    = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    assign carry_next = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_a_d  = bus.a;
                    op_b_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                carry_d = carry_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // carry_q here is the carry into the MSB; carry_next is the carry out of it.
                    result_d    = {sum_bit, acc_q[WIDTH-1:1]};
                    carry_out_d = carry_next;
                    overflow_d  = carry_q ^ carry_next;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub (WIDTH=8): directed arithmetic cases, handshake timing, reset abort,
// back-to-back operation and a random sweep, all checked through an expected-result queue.
module tb_serial_add_sub;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    serial_add_sub_if #(.WIDTH(W)) bus ();

    serial_add_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int cyc      = 0;

    // Each entry is {result, carry_out, overflow}.
    logic [W+1:0] exp_q[$];
    logic [W+1:0] mon_exp;
    logic [W+1:0] mon_got;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            done_cnt++;
            checks++;
            mon_got = {bus.result, bus.carry_out, bus.overflow};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got {result,cout,ovf}=%h with no pending op", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL scoreboard: got result=%0d cout=%0b ovf=%0b, expected result=%0d cout=%0b ovf=%0b",
                             mon_got[W+1:2], mon_got[1], mon_got[0], mon_exp[W+1:2], mon_exp[1], mon_exp[0]);
                end
            end
        end
    end

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic [W:0]   full;
        logic [W-1:0] r;
        logic         v;
        if (sub) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else     full = {1'b0, a} + {1'b0, b};
        r = full[W-1:0];
        if (sub) v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        else     v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        return {r, full[W], v};
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic [W+1:0] exp, output int lat, output int busy_n);
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        bus.start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.sub   = 1'($urandom);
        lat    = 0;
        busy_n = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: no done within 20 cycles for a=%0d b=%0d sub=%0b", a, b, sub);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.carry_out, bus.overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/cout/ovf=%b, expected 0000",
                     {bus.busy, bus.done, bus.carry_out, bus.overflow});
        end
        checks++;
        if (bus.result !== '0) begin
            errors++;
            $display("FAIL reset_result: got %0d, expected 0", bus.result);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d, expected 0", dbg_state);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int lat, bn;
        run_op(8'd100, 8'd27, 1'b0, {8'd127, 1'b0, 1'b0}, lat, bn);
        checks++;
        if (lat != W + 1) begin
            errors++;
            $display("FAIL add_latency: got %0d cycles, expected %0d", lat, W + 1);
        end
        checks++;
        if (bn != W + 1) begin
            errors++;
            $display("FAIL add_busy_len: got %0d cycles, expected %0d", bn, W + 1);
        end
        run_op(8'd200, 8'd100, 1'b0, {8'd44, 1'b1, 1'b0}, lat, bn);
        run_op(8'd127, 8'd1, 1'b0, {8'd128, 1'b0, 1'b1}, lat, bn);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.result, bus.busy, bus.done} !== {8'd128, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_hold: got result=%0d busy=%0b done=%0b, expected 128 0 0",
                     bus.result, bus.busy, bus.done);
        end
    endtask

    task automatic test_sub();
        int lat, bn;
        run_op(8'd5, 8'd3, 1'b1, {8'd2, 1'b1, 1'b0}, lat, bn);
        run_op(8'd3, 8'd5, 1'b1, {8'd254, 1'b0, 1'b0}, lat, bn);
        run_op(8'h80, 8'd1, 1'b1, {8'h7F, 1'b1, 1'b1}, lat, bn);
    endtask

    task automatic test_ignore_start();
        int  base;
        bit  held_ok;
        bit  seen;
        base    = done_cnt;
        held_ok = 1'b1;
        seen    = 1'b0;
        bus.a     = 8'd10;
        bus.b     = 8'd20;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        exp_q.push_back({8'd30, 1'b0, 1'b0});
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 8'd1;
        bus.b     = 8'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.result !== 8'h7F) held_ok = 1'b0;
        end
        checks++;
        if (!seen || !held_ok) begin
            errors++;
            $display("FAIL ignore_hold: done_seen=%0b prev_result_held=%0b, expected 1 1", seen, held_ok);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (done_cnt - base != 1) begin
            errors++;
            $display("FAIL ignore_single_done: got %0d done pulses, expected 1", done_cnt - base);
        end
        checks++;
        if ({bus.busy, dbg_state} !== 3'b000) begin
            errors++;
            $display("FAIL ignore_idle: got busy=%0b state=%0d, expected 0 0", bus.busy, dbg_state);
        end
    endtask

    task automatic test_reset_mid();
        int base, lat, bn;
        bus.a     = 8'd50;
        bus.b     = 8'd60;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        base = done_cnt;
        rst  = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow, dbg_state} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%0b done=%0b result=%0d cout=%0b ovf=%0b state=%0d, expected all 0",
                     bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow, dbg_state);
        end
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != base) begin
            errors++;
            $display("FAIL midreset_no_done: got %0d done pulses, expected 0", done_cnt - base);
        end
        run_op(8'd9, 8'd9, 1'b0, {8'd18, 1'b0, 1'b0}, lat, bn);
    endtask

    task automatic test_back_to_back();
        int dc[3];
        int k;
        k = 0;
        bus.a     = 8'd1;
        bus.b     = 8'd2;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        exp_q.push_back({8'd3, 1'b0, 1'b0});
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.done) begin
                dc[k] = cyc;
                k++;
                if (k == 1) begin
                    bus.a = 8'd250; bus.b = 8'd10; bus.sub = 1'b0;
                    exp_q.push_back({8'd4, 1'b1, 1'b0});
                end else if (k == 2) begin
                    bus.a = 8'd7; bus.b = 8'd9; bus.sub = 1'b1;
                    exp_q.push_back({8'd254, 1'b0, 1'b0});
                end else begin
                    bus.start = 1'b0;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (k != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d done pulses, expected 3", k);
        end else begin
            checks++;
            if (dc[1] - dc[0] != W + 2 || dc[2] - dc[1] != W + 2) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d and %0d cycles, expected %0d",
                         dc[1] - dc[0], dc[2] - dc[1], W + 2);
            end
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: got busy=%0b, expected 0", bus.busy);
        end
    endtask

    task automatic test_random();
        int lat, bn;
        logic [W-1:0] a, b;
        logic         s;
        for (int i = 0; i < 500; i++) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            run_op(a, b, s, model(a, b, s), lat, bn);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_ops: got %0d results still outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
